// File: rtl/prog_mem_loader.sv
// Program RAM for the CPU fetch port: zeroed after reset, reloadable from a
// valid/ready byte stream while the CPU is held in reset.
module prog_mem_loader #(
  parameter int AW      = 4,
  parameter int DEPTH   = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] adr,
  output logic [DW-1:0] dout,
  output logic          cpu_run,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          ld_err,
  output logic [DW-1:0] chk
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_ADR  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {CLEAR, RUN, LOAD, DONE} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] idle_cnt;
  logic [DW-1:0] mem [DEPTH];

  logic          hs;
  logic          we;
  logic [DW-1:0] wd;

  function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a + b;
  endfunction

  assign hs = (state == LOAD) & ld_valid & ld_ready;
  // CLEAR writes NOPs; a reset edge never writes, so an interrupted load cannot land a byte.
  assign we = ~reset & ((state == CLEAR) | hs);
  assign wd = (state == LOAD) ? ld_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      wr_ptr   <= '0;
      cpu_run  <= 1'b0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      ld_err   <= 1'b0;
      chk      <= '0;
      idle_cnt <= '0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        CLEAR: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == LAST_ADR) begin
            state   <= RUN;
            cpu_run <= 1'b1;
          end
        end
        RUN: begin
          if (ld_start) begin
            state    <= LOAD;
            cpu_run  <= 1'b0;
            ld_ready <= 1'b1;
            wr_ptr   <= '0;
            chk      <= '0;
            ld_err   <= 1'b0;
            idle_cnt <= '0;
          end
        end
        LOAD: begin
          if (hs) begin
            chk      <= wrap_add(chk, ld_data);
            wr_ptr   <= wr_ptr + 1'b1;
            idle_cnt <= '0;
            if (wr_ptr == LAST_ADR) begin
              state    <= DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            // Abort keeps whatever was already written; CPU resumes on the mixed image.
            state    <= RUN;
            ld_err   <= 1'b1;
            ld_ready <= 1'b0;
            cpu_run  <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DONE: begin
          state   <= RUN;
          cpu_run <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wd;
  end

  assign dout = cpu_run ? mem[adr] : '0;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized scoreboard bench for prog_mem_loader: load outcomes are queued at
// stimulus time and popped by a monitor on ld_done / rising ld_err.
module tb_prog_mem_loader;
  localparam int AW = 4, DEPTH = 16, DW = 8, TIMEOUT = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] adr = '0;
  logic [DW-1:0] dout;
  logic          cpu_run;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          ld_done;
  logic          ld_err;
  logic [DW-1:0] chk;

  always #5 clk = ~clk;

  prog_mem_loader #(.AW(AW), .DEPTH(DEPTH), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .adr(adr), .dout(dout), .cpu_run(cpu_run),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err), .chk(chk)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] sum;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] stim[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each ld_done or rising ld_err must match the oldest queued outcome.
  logic err_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (ld_done || (ld_err && !err_q))) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got done=%0b err=%0b, expected no event", ld_done, ld_err);
      end else begin
        e = sb.pop_front();
        check("event_kind", {30'd0, ld_done, ld_err & ~err_q}, e.is_err ? 32'd1 : 32'd2);
        check("event_chk", chk, e.sum);
      end
    end
    err_q <= ld_err;
  end

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      adr = AW'(a);
      #1;
      check($sformatf("%s_dout[%0d]", tag, a), dout, ref_mem[a]);
    end
  endtask

  task automatic reset_and_clear(input bit poke_start, input bit start_with_rst);
    bit ok;
    ok = 1'b1;
    reset = 1'b1;
    ld_start = start_with_rst;
    tick();
    reset = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      ld_start = poke_start && (i == 5);
      @(negedge clk);
      if (i == 0) check("ready_after_reset", {ld_ready, ld_err, ld_done}, 3'b000);
      if (cpu_run !== 1'b0 || ld_ready !== 1'b0) ok = 1'b0;
      tick();
    end
    ld_start = 1'b0;
    check("clear_held_16", {31'd0, ok}, 32'd1);
    @(negedge clk);
    check("run_after_clear", {cpu_run, ld_ready, ld_err}, 3'b100);
    check("chk_after_reset", chk, 8'h00);
    read_all("clear");
  endtask

  task automatic run_load(input int gap_min, input int gap_max, input bit poke_start, input bit expect_done);
    int         wait_cnt;
    logic [7:0] sum;
    exp_t       e;
    sum = 8'h00;
    foreach (stim[i]) sum = sum + stim[i];
    @(negedge clk);
    check("run_before_load", {cpu_run, ld_ready}, 2'b10);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("load_entry", {cpu_run, ld_ready, ld_err}, 3'b010);
    e.is_err = !expect_done;
    e.sum = sum;
    sb.push_back(e);
    for (int i = 0; i < stim.size(); i++) begin
      ld_valid = 1'b1;
      ld_data = stim[i];
      ld_start = poke_start && (i == 3);
      wait_cnt = 0;
      while (!ld_ready && wait_cnt < 50) begin
        tick();
        wait_cnt++;
      end
      if (wait_cnt >= 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL ready_wait: got ld_ready=0 for 50 cycles, expected 1");
      end
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ref_mem[i] = stim[i];
      if (i != stim.size() - 1) repeat ($urandom_range(gap_max, gap_min)) tick();
    end
    if (expect_done) begin
      @(negedge clk);
      check("done_pulse", {ld_done, cpu_run, ld_ready}, 3'b100);
      @(negedge clk);
      check("run_after_done", {ld_done, cpu_run, ld_err}, 3'b010);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by 2 ms, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and clear
    reset_and_clear(1'b0, 1'b0);

    // Back-to-back load A0..AF
    stim.delete();
    for (int i = 0; i < DEPTH; i++) stim.push_back(8'hA0 + 8'(i));
    run_load(0, 0, 1'b0, 1'b1);
    check("chk_a0_af", chk, 8'h78);
    read_all("seq");

    // Alternating valid, bytes 00..0F
    stim.delete();
    for (int i = 0; i < DEPTH; i++) stim.push_back(8'(i));
    run_load(1, 1, 1'b0, 1'b1);
    check("chk_00_0f", chk, 8'h78);
    check("err_toggle", ld_err, 1'b0);
    read_all("toggle");

    // Timeout after five bytes
    stim.delete();
    stim.push_back(8'h11); stim.push_back(8'h22); stim.push_back(8'h33);
    stim.push_back(8'h44); stim.push_back(8'h55);
    run_load(0, 0, 1'b0, 1'b0);
    repeat (TIMEOUT - 1) tick();
    check("err_not_early", {ld_err, ld_ready}, 2'b01);
    tick();
    check("err_set", {ld_err, cpu_run, ld_ready, ld_done}, 4'b1100);
    read_all("timeout");

    // Reset in the middle of a load, ld_start coincident with reset and poked in CLEAR
    stim.delete();
    @(negedge clk);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1;
      ld_data = 8'($urandom);
      tick();
    end
    ld_data = 8'($urandom);
    reset_and_clear(1'b1, 1'b1);
    check("err_after_reset", ld_err, 1'b0);

    // Random loads, ld_start poked mid-load, random gaps
    for (int r = 0; r < 3; r++) begin
      stim.delete();
      for (int i = 0; i < DEPTH; i++) stim.push_back(8'($urandom));
      run_load(0, 3, r != 1, 1'b1);
      check("err_random", ld_err, 1'b0);
      read_all("rand");
    end

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
